// File: rtl/x25519_pkg.sv
// x25519_pkg: shared field constants and sequencer state for the x25519 datapath.
package x25519_pkg;
    localparam int FE_W = 255;
    localparam int DEF_LIMB_W = 64;
    localparam logic [FE_W-1:0] P25519 = {FE_W{1'b1}} - FE_W'(18);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/addmod_seq_if.sv
// addmod_seq_if: operand/result valid-ready bus of the limb-serial modular adder.
interface addmod_seq_if;
    import x25519_pkg::*;
    logic in_valid;
    logic in_ready;
    logic [FE_W-1:0] a;
    logic [FE_W-1:0] b;
    logic out_valid;
    logic out_ready;
    logic [FE_W-1:0] z;
    modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, z);
    modport slave (input in_valid, a, b, out_ready, output in_ready, out_valid, z);
endinterface

// File: rtl/addsub_limb.sv
// addsub_limb: one limb of a + b + carry, then that fresh sum minus p minus borrow.
module addsub_limb #(
    parameter int LIMB_W = 64
) (
    input  logic [LIMB_W-1:0] i_a,
    input  logic [LIMB_W-1:0] i_b,
    input  logic [LIMB_W-1:0] i_p,
    input  logic              i_carry,
    input  logic              i_borrow,
    output logic [LIMB_W-1:0] o_s,
    output logic [LIMB_W-1:0] o_t,
    output logic              o_carry,
    output logic              o_borrow
);
    logic [LIMB_W:0] w_sum;
    logic [LIMB_W:0] w_dif;
    always_comb begin
        w_sum = {1'b0, i_a} + {1'b0, i_b} + (LIMB_W+1)'(i_carry);
        w_dif = {1'b0, w_sum[LIMB_W-1:0]} - {1'b0, i_p} - (LIMB_W+1)'(i_borrow);
    end
    assign o_s = w_sum[LIMB_W-1:0];
    assign o_carry = w_sum[LIMB_W];
    assign o_t = w_dif[LIMB_W-1:0];
    assign o_borrow = w_dif[LIMB_W];
endmodule

// File: rtl/addmod_seq.sv
// addmod_seq: limb-serial z = (a + b) mod (2^255 - 19), one limb per cycle.
// Define ADDMOD_STATS_EN to add reduce_cnt, counting delivered results that needed the subtraction.
module addmod_seq
    import x25519_pkg::*;
#(
    parameter int LIMB_W = DEF_LIMB_W
) (
    input  logic        clk,
    input  logic        rst,
    addmod_seq_if.slave bus
`ifdef ADDMOD_STATS_EN
    ,
    output logic [31:0] reduce_cnt
`endif
);
    localparam int NLIMB = (256 + LIMB_W - 1) / LIMB_W;
    localparam int W = NLIMB * LIMB_W;
    localparam int IDX_W = (NLIMB > 1) ? $clog2(NLIMB) : 1;
    localparam logic [W-1:0] P_PAD = W'(P25519);

    state_t r_state, w_state_nxt;
    logic [W-1:0] r_a, r_b, r_s, r_t;
    logic [IDX_W-1:0] r_idx;
    logic r_carry, r_borrow;
    logic [LIMB_W-1:0] w_s, w_t;
    logic w_carry, w_borrow, w_last, w_accept;

    addsub_limb #(.LIMB_W(LIMB_W)) u_limb (
        .i_a      (r_a[r_idx*LIMB_W +: LIMB_W]),
        .i_b      (r_b[r_idx*LIMB_W +: LIMB_W]),
        .i_p      (P_PAD[r_idx*LIMB_W +: LIMB_W]),
        .i_carry  (r_carry),
        .i_borrow (r_borrow),
        .o_s      (w_s),
        .o_t      (w_t),
        .o_carry  (w_carry),
        .o_borrow (w_borrow)
    );

    always_comb begin
        bus.in_ready = r_state == IDLE;
        bus.out_valid = r_state == DONE;
        // Final borrow clear means S >= p, so the reduced value T is the answer
        bus.z = r_borrow ? r_s[FE_W-1:0] : r_t[FE_W-1:0];
        w_last = r_idx == IDX_W'(NLIMB - 1);
        w_accept = bus.in_valid && bus.in_ready;
        w_state_nxt = (r_state == IDLE && w_accept) ? RUN :
                      (r_state == RUN && w_last) ? DONE :
                      (r_state == DONE && bus.out_ready) ? IDLE : r_state;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
            r_s <= '0;
            r_t <= '0;
            r_idx <= '0;
            r_carry <= 1'b0;
            r_borrow <= 1'b0;
        end else if (w_accept) begin
            r_a <= W'(bus.a);
            r_b <= W'(bus.b);
            r_idx <= '0;
            r_carry <= 1'b0;
            r_borrow <= 1'b0;
        end else if (r_state == RUN) begin
            r_s[r_idx*LIMB_W +: LIMB_W] <= w_s;
            r_t[r_idx*LIMB_W +: LIMB_W] <= w_t;
            r_carry <= w_carry;
            r_borrow <= w_borrow;
            r_idx <= w_last ? '0 : r_idx + 1'b1;
        end
    end

`ifdef ADDMOD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) reduce_cnt <= '0;
        else if (bus.out_valid && bus.out_ready && !r_borrow) reduce_cnt <= reduce_cnt + 32'd1;
    end
`endif
endmodule
